writeback_stage: RTL and testbench

- Final pipeline stage directly upstream of the register file; drives its rd_addr/rd_data write port.
- Merges single-cycle pipeline results with out-of-order long-latency results (mul/div/load unit) buffered in a small FIFO.
- Keeps a pending-register scoreboard for issue stalls.
- Forwards the in-flight writeback value to operand read.

---
 rtl/writeback_stage.sv | 157 +++++++++++++++
 tb/tb_writeback_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage
// Last pipeline stage before the register file. Each clock edge it fills one
// registered write slot (o_rd_addr/o_rd_data) with one of:
//   1. a single-cycle pipeline result (highest priority),
//   2. the head of a small FIFO of long-latency unit results (mul/div/load),
//   3. nothing (o_rd_addr = 0, o_rd_data holds).
// A 32-bit scoreboard tracks destinations of issued long ops so decode can
// stall. The slot contents are forwarded to operand read.
//
// Ports:
//   i_clk, i_rst                        clock, async active-high reset
//   i_pipe_valid/rd_addr/rd_data        single-cycle result
//   i_lu_issue/i_lu_issue_rd            long op issued (sets scoreboard bit)
//   i_lu_valid/rd_addr/rd_data          long-unit result, accepted when o_lu_ready
//   o_lu_ready                          FIFO not full
//   o_rd_addr/o_rd_data                 regfile write port (addr 0 = no write)
//   i_rs1_addr/i_rs2_addr               decode source registers
//   o_rs1_busy/o_rs2_busy               source has an outstanding long op
//   o_rs1_fwd/o_rs2_fwd                 source matches in-flight write slot
//   o_pending_count                     number of pending scoreboard bits
//   o_conflict                          sticky hazard-violation flag
module writeback_stage #(
    parameter int LU_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pipe_valid,
    input  logic [4:0]  i_pipe_rd_addr,
    input  logic [31:0] i_pipe_rd_data,
    input  logic        i_lu_issue,
    input  logic [4:0]  i_lu_issue_rd,
    input  logic        i_lu_valid,
    input  logic [4:0]  i_lu_rd_addr,
    input  logic [31:0] i_lu_rd_data,
    output logic        o_lu_ready,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic        o_rs1_busy,
    output logic        o_rs2_busy,
    output logic        o_rs1_fwd,
    output logic        o_rs2_fwd,
    output logic [5:0]  o_pending_count,
    output logic        o_conflict
);

    localparam int IDX_W = $clog2(LU_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // ---------------- long-unit result FIFO ----------------
    logic [LU_DEPTH-1:0][4:0]  fifo_rd;
    logic [LU_DEPTH-1:0][31:0] fifo_data;
    logic [PTR_W-1:0]          wptr, rptr;
    logic                      full, empty, push, pop;
    logic [4:0]                head_rd;
    logic [31:0]               head_data;

    // Pointers carry one extra wrap bit: equal low bits with differing MSB
    // means full, identical pointers mean empty.
    assign full  = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                   (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);
    assign empty = (wptr == rptr);

    assign o_lu_ready = !full;
    assign push       = i_lu_valid && !full;

    assign head_rd   = fifo_rd[rptr[IDX_W-1:0]];
    assign head_data = fifo_data[rptr[IDX_W-1:0]];

    // A pipeline result that actually writes takes the slot; rd=0 pipeline
    // traffic never blocks the FIFO drain.
    logic pipe_commit;
    assign pipe_commit = i_pipe_valid && (i_pipe_rd_addr != 5'd0);
    assign pop         = !pipe_commit && !empty;

    // Storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_rd[wptr[IDX_W-1:0]]   <= i_lu_rd_addr;
            fifo_data[wptr[IDX_W-1:0]] <= i_lu_rd_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
        end
    end

    // ---------------- commit slot ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_addr <= 5'd0;
            o_rd_data <= 32'd0;
        end else if (pipe_commit) begin
            o_rd_addr <= i_pipe_rd_addr;
            o_rd_data <= i_pipe_rd_data;
        end else if (pop) begin
            o_rd_addr <= head_rd;       // rd=0 entries commit as no-write
            o_rd_data <= head_data;
        end else begin
            o_rd_addr <= 5'd0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] pending, pending_nxt;
    logic [5:0]  count_nxt;
    logic        issue_set;
    logic        conflict_evt;

    assign issue_set = i_lu_issue && (i_lu_issue_rd != 5'd0);

    // Clear first, then set, so a same-cycle issue to the popping rd keeps
    // the bit pending.
    always_comb begin
        pending_nxt = pending;
        if (pop && head_rd != 5'd0) pending_nxt[head_rd] = 1'b0;
        if (issue_set)              pending_nxt[i_lu_issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_comb begin
        count_nxt = 6'd0;
        for (int i = 1; i < 32; i++) count_nxt = count_nxt + {5'd0, pending_nxt[i]};
    end

    // Hazards judged against the pre-edge scoreboard. x0 is never tracked,
    // so rd=0 results are not treated as unexpected.
    assign conflict_evt = (issue_set && pending[i_lu_issue_rd]) ||
                          (pipe_commit && pending[i_pipe_rd_addr]) ||
                          (push && (i_lu_rd_addr != 5'd0) && !pending[i_lu_rd_addr]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending         <= 32'd0;
            o_pending_count <= 6'd0;
            o_conflict      <= 1'b0;
        end else begin
            pending         <= pending_nxt;
            o_pending_count <= count_nxt;
            if (conflict_evt) o_conflict <= 1'b1;
        end
    end

    // ---------------- decode-side status ----------------
    assign o_rs1_busy = pending[i_rs1_addr];
    assign o_rs2_busy = pending[i_rs2_addr];
    assign o_rs1_fwd  = (o_rd_addr != 5'd0) && (o_rd_addr == i_rs1_addr);
    assign o_rs2_fwd  = (o_rd_addr != 5'd0) && (o_rd_addr == i_rs2_addr);

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_pipe_valid;
    logic [4:0]  i_pipe_rd_addr;
    logic [31:0] i_pipe_rd_data;
    logic        i_lu_issue;
    logic [4:0]  i_lu_issue_rd;
    logic        i_lu_valid;
    logic [4:0]  i_lu_rd_addr;
    logic [31:0] i_lu_rd_data;
    logic        o_lu_ready;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic        o_rs1_busy, o_rs2_busy, o_rs1_fwd, o_rs2_fwd;
    logic [5:0]  o_pending_count;
    logic        o_conflict;

    writeback_stage #(.LU_DEPTH(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_pipe_valid(i_pipe_valid), .i_pipe_rd_addr(i_pipe_rd_addr),
        .i_pipe_rd_data(i_pipe_rd_data),
        .i_lu_issue(i_lu_issue), .i_lu_issue_rd(i_lu_issue_rd),
        .i_lu_valid(i_lu_valid), .i_lu_rd_addr(i_lu_rd_addr),
        .i_lu_rd_data(i_lu_rd_data), .o_lu_ready(o_lu_ready),
        .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
        .o_rs1_fwd(o_rs1_fwd), .o_rs2_fwd(o_rs2_fwd),
        .o_pending_count(o_pending_count), .o_conflict(o_conflict)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        rdy, b1, b2, f1, f2;
        logic [5:0]  cnt;
        logic        conf;
    } out_t;

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pdata;
        logic        iss;
        logic [4:0]  ird;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic [4:0]  rs1, rs2;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    task automatic add(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                       input logic iss, input logic [4:0] ird,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] ea, input logic [31:0] ed, input logic er,
                       input logic eb1, input logic eb2, input logic ef1, input logic ef2,
                       input logic [5:0] ec, input logic ecf);
        vec_t v;
        v.pv = pv; v.prd = prd; v.pdata = pdata; v.iss = iss; v.ird = ird;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata; v.rs1 = rs1; v.rs2 = rs2;
        v.exp = '{addr: ea, data: ed, rdy: er, b1: eb1, b2: eb2, f1: ef1, f2: ef2,
                  cnt: ec, conf: ecf};
        vecs.push_back(v);
    endtask

    function automatic out_t sample();
        return '{addr: o_rd_addr, data: o_rd_data, rdy: o_lu_ready,
                 b1: o_rs1_busy, b2: o_rs2_busy, f1: o_rs1_fwd, f2: o_rs2_fwd,
                 cnt: o_pending_count, conf: o_conflict};
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = sample();
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got addr=%0d data=%h rdy=%b busy=%b%b fwd=%b%b cnt=%0d conf=%b, want addr=%0d data=%h rdy=%b busy=%b%b fwd=%b%b cnt=%0d conf=%b",
                      name, act.addr, act.data, act.rdy, act.b1, act.b2, act.f1, act.f2,
                      act.cnt, act.conf, exp.addr, exp.data, exp.rdy, exp.b1, exp.b2,
                      exp.f1, exp.f2, exp.cnt, exp.conf);
    endtask

    task automatic drive(input vec_t v);
        i_pipe_valid = v.pv; i_pipe_rd_addr = v.prd; i_pipe_rd_data = v.pdata;
        i_lu_issue = v.iss;  i_lu_issue_rd = v.ird;
        i_lu_valid = v.lv;   i_lu_rd_addr = v.lrd;   i_lu_rd_data = v.ldata;
        i_rs1_addr = v.rs1;  i_rs2_addr = v.rs2;
    endtask

    // Drive one cycle of inputs, clock, check 1 time unit after the edge.
    task automatic run_vec(input string name, input vec_t v);
        drive(v);
        @(posedge i_clk);
        #1;
        check(name, v.exp);
    endtask

    // Reset asserted between clock edges; checked before any edge occurs.
    task automatic mid_reset(input string name, input logic [4:0] rs1);
        vec_t idle;
        idle = '{default: '0};
        idle.rs1 = rs1;
        #2;
        drive(idle);
        i_rst = 1'b1;
        #1;
        check(name, '{addr: 5'd0, data: 32'd0, rdy: 1'b1, b1: 1'b0, b2: 1'b0,
                      f1: 1'b0, f2: 1'b0, cnt: 6'd0, conf: 1'b0});
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                                input logic iss, input logic [4:0] ird,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                                input logic [4:0] rs1,
                                input logic [4:0] ea, input logic [31:0] ed,
                                input logic eb1, input logic ef1,
                                input logic [5:0] ec, input logic ecf);
        vec_t v;
        v = '{default: '0};
        v.pv = pv; v.prd = prd; v.pdata = pdata; v.iss = iss; v.ird = ird;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata; v.rs1 = rs1;
        v.exp = '{addr: ea, data: ed, rdy: 1'b1, b1: eb1, b2: 1'b0, f1: ef1, f2: 1'b0,
                  cnt: ec, conf: ecf};
        return v;
    endfunction

    initial begin
        //   pv prd pdata        iss ird lv lrd ldata   rs1 rs2  addr data         rdy b1 b2 f1 f2 cnt conf
        // pipe write and forward
        add(1, 5, 32'hDEADBEEF, 0, 0,  0, 0, 0,       5, 0,   5, 32'hDEADBEEF, 1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0,            0, 0,  0, 0, 0,       5, 0,   0, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 0);
        // single long op rd=7
        add(0, 0, 0,            1, 7,  0, 0, 0,       0, 7,   0, 32'hDEADBEEF, 1, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0,            0, 0,  1, 7, 32'h12,  0, 7,   0, 32'hDEADBEEF, 1, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0,            0, 0,  0, 0, 0,       0, 7,   7, 32'h12,       1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0,            0, 0,  0, 0, 0,       0, 7,   0, 32'h12,       1, 0, 0, 0, 0, 0, 0);
        // FIFO fills while pipe holds the slot, then drains in order
        add(0, 0, 0,            1, 3,  0, 0, 0,       3, 4,   0, 32'h12,       1, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0,            1, 4,  0, 0, 0,       3, 4,   0, 32'h12,       1, 1, 1, 0, 0, 2, 0);
        add(1, 9, 32'h900,      0, 0,  1, 3, 32'h33,  3, 4,   9, 32'h900,      1, 1, 1, 0, 0, 2, 0);
        add(1, 9, 32'h901,      0, 0,  1, 4, 32'h44,  3, 4,   9, 32'h901,      0, 1, 1, 0, 0, 2, 0);
        add(1, 9, 32'h902,      0, 0,  0, 0, 0,       3, 4,   9, 32'h902,      0, 1, 1, 0, 0, 2, 0);
        add(0, 0, 0,            0, 0,  0, 0, 0,       3, 4,   3, 32'h33,       1, 0, 1, 1, 0, 1, 0);
        add(0, 0, 0,            0, 0,  0, 0, 0,       3, 4,   4, 32'h44,       1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0,            0, 0,  0, 0, 0,       3, 4,   0, 32'h44,       1, 0, 0, 0, 0, 0, 0);
        // x0: no scoreboard bit, no write, rd=0 entry pops as no-write
        add(1, 0, 32'h555,      1, 0,  1, 0, 32'h666, 0, 0,   0, 32'h44,       1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0,            0, 0,  0, 0, 0,       0, 0,   0, 32'h666,      1, 0, 0, 0, 0, 0, 0);
        // same-cycle set and clear of rd=6
        add(0, 0, 0,            1, 6,  0, 0, 0,       6, 0,   0, 32'h666,      1, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0,            0, 0,  1, 6, 32'h66,  6, 0,   0, 32'h666,      1, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0,            1, 6,  0, 0, 0,       6, 0,   6, 32'h66,       1, 1, 0, 1, 0, 1, 1);
        add(0, 0, 0,            0, 0,  0, 0, 0,       6, 0,   0, 32'h66,       1, 1, 0, 0, 0, 1, 1);
        // load up 3 pending bits and 2 FIFO entries before a mid-cycle reset
        add(0, 0, 0,            1, 10, 0, 0, 0,       10, 11, 0, 32'h66,       1, 1, 0, 0, 0, 2, 1);
        add(0, 0, 0,            1, 11, 0, 0, 0,       10, 11, 0, 32'h66,       1, 1, 1, 0, 0, 3, 1);
        add(1, 20, 32'h1,       0, 0,  1, 10, 32'hAA, 10, 11, 20, 32'h1,       1, 1, 1, 0, 0, 3, 1);
        add(1, 20, 32'h2,       0, 0,  1, 11, 32'hBB, 10, 11, 20, 32'h2,       0, 1, 1, 0, 0, 3, 1);

        // power-on reset
        drive('{default: '0});
        i_rst = 1'b1;
        #1;
        check("reset_state", '{addr: 5'd0, data: 32'd0, rdy: 1'b1, b1: 1'b0, b2: 1'b0,
                               f1: 1'b0, f2: 1'b0, cnt: 6'd0, conf: 1'b0});
        @(negedge i_clk);
        i_rst = 1'b0;

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // async reset with FIFO full and pending bits set
        mid_reset("async_reset", 5'd10);
        // FIFO contents were discarded: nothing drains afterwards
        run_vec("post_reset_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 32'd0, 0, 0, 0, 0));
        // result push with no pending bit raises conflict, entry still commits
        run_vec("orphan_push",     mk(0, 0, 0, 0, 0, 1, 13, 32'h13, 13, 0, 32'd0, 0, 0, 0, 1));
        run_vec("orphan_commit",   mk(0, 0, 0, 0, 0, 0, 0, 0, 13, 13, 32'h13, 0, 1, 0, 1));
        // pipe commit to a pending rd (WAW) raises conflict
        mid_reset("reset_again", 5'd13);
        run_vec("issue14",         mk(0, 0, 0, 1, 14, 0, 0, 0, 14, 0, 32'd0, 1, 0, 1, 0));
        run_vec("waw_pipe14",      mk(1, 14, 32'h14, 0, 0, 0, 0, 0, 14, 14, 32'h14, 1, 1, 1, 1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1);
    end

endmodule
